// File: rtl/step_move_sequencer.sv
// step_move_sequencer: command FIFO plus STEP/DIR sequencer for one stepper axis.
// The host queues {dir, count, period} moves; they run back-to-back with DIR
// setup time, pause gating from drv_en_SM between pulses, and a global abort.
// STEP is a one-clock-delayed copy of the HIGH state, so every phase length
// seen on the pin equals the time the FSM spends in that state.
// Optional build macro: STEP_SEQ_POSITION_EN adds a signed position counter
// (output position) and its pos_clear input.
module step_move_sequencer #(
    parameter int SIZE       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIR_SETUP  = 8,
    parameter int MIN_PERIOD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_dir,
    input  logic [SIZE-1:0]          cmd_count,
    input  logic [SIZE-1:0]          cmd_period,
    input  logic                     drv_en_SM,
    input  logic                     abort,
`ifdef STEP_SEQ_POSITION_EN
    input  logic                     pos_clear,
    output logic signed [2*SIZE-1:0] position,
`endif
    output logic                     step,
    output logic                     dir,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [SIZE-1:0]          fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     DEPTH_L  = (AW+1)'(FIFO_DEPTH);
    localparam logic [SIZE-1:0] MIN_L    = SIZE'(MIN_PERIOD);
    localparam logic [SIZE-1:0] SETUP_M1 = SIZE'(DIR_SETUP - 1);
    localparam logic [SIZE-1:0] ONE      = SIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DIR_WAIT, S_HIGH, S_LOW, S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Command FIFO storage and bookkeeping
    logic            mem_dir    [FIFO_DEPTH];
    logic [SIZE-1:0] mem_count  [FIFO_DEPTH];
    logic [SIZE-1:0] mem_period [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     level_reg;
    logic            push, pop;

    // Move datapath
    logic [SIZE-1:0] timer_reg, count_reg, period_reg, high_reg;
    logic            dir_reg, step_reg, done_reg, aborted_reg;

    // Head-of-queue decode used in LOAD
    logic            head_dir;
    logic [SIZE-1:0] head_count, head_period, p_clamp, p_shift, h_calc;

    // Abort wins over a same-cycle push; LOAD always has a valid head
    assign push = cmd_valid && cmd_ready && !abort;
    assign pop  = (state_reg == S_LOAD) && !abort;

    assign head_dir    = mem_dir[rd_ptr_reg];
    assign head_count  = mem_count[rd_ptr_reg];
    assign head_period = mem_period[rd_ptr_reg];
    assign p_clamp     = (head_period < MIN_L) ? MIN_L : head_period;
    assign p_shift     = p_clamp >> 2;
    assign h_calc      = (p_shift == '0) ? ONE : p_shift;

    // FIFO write port (storage has no reset; validity is tracked by level_reg)
    always_ff @(posedge clk) begin
        if (push) begin
            mem_dir[wr_ptr_reg]    <= cmd_dir;
            mem_count[wr_ptr_reg]  <= cmd_count;
            mem_period[wr_ptr_reg] <= cmd_period;
        end
    end

    // FIFO pointers and level; abort flushes everything
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      level_reg <= level_reg + 1'b1;
            else if (pop && !push) level_reg <= level_reg - 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE:     if (level_reg != '0) state_next = S_LOAD;
                S_LOAD: begin
                    if (head_count == '0)       state_next = S_DONE;
                    else if (head_dir != dir_reg) state_next = S_DIR_WAIT;
                    else                        state_next = S_HIGH;
                end
                S_DIR_WAIT: if (timer_reg == '0) state_next = S_HIGH;
                S_HIGH:     if (timer_reg == '0) state_next = S_LOW;
                S_LOW: begin
                    if (timer_reg == '0) begin
                        if (count_reg == ONE) state_next = S_DONE;
                        else if (drv_en_SM)   state_next = S_HIGH;
                    end
                end
                S_DONE:     state_next = (level_reg != '0) ? S_LOAD : S_IDLE;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // FSM output logic (combinational status)
    always_comb begin
        cmd_ready = (level_reg < DEPTH_L);
        busy      = (state_reg != S_IDLE) || (level_reg != '0);
    end

    // Phase timer, pulse counter, latched command and DIR level
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_reg  <= '0;
            count_reg  <= '0;
            period_reg <= '0;
            high_reg   <= '0;
            dir_reg    <= 1'b0;
        end else if (!abort) begin
            case (state_reg)
                S_LOAD: begin
                    period_reg <= p_clamp;
                    high_reg   <= h_calc;
                    count_reg  <= head_count;
                    if (head_count != '0 && head_dir != dir_reg) begin
                        dir_reg   <= head_dir;
                        timer_reg <= SETUP_M1;
                    end else begin
                        timer_reg <= h_calc - ONE;
                    end
                end
                S_DIR_WAIT: begin
                    if (timer_reg != '0) timer_reg <= timer_reg - ONE;
                    else                 timer_reg <= high_reg - ONE;
                end
                S_HIGH: begin
                    if (timer_reg != '0) timer_reg <= timer_reg - ONE;
                    else                 timer_reg <= period_reg - high_reg - ONE;
                end
                S_LOW: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - ONE;
                    end else if (count_reg != ONE && drv_en_SM) begin
                        count_reg <= count_reg - ONE;
                        timer_reg <= high_reg - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered pin-side outputs: step trails the HIGH state by one clock
    always_ff @(posedge clk) begin
        if (rst) begin
            step_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            step_reg    <= (state_reg == S_HIGH) && !abort;
            done_reg    <= (state_next == S_DONE);
            aborted_reg <= abort;
        end
    end

    assign step       = step_reg;
    assign dir        = dir_reg;
    assign done       = done_reg;
    assign aborted    = aborted_reg;
    assign fifo_level = SIZE'(level_reg);

`ifdef STEP_SEQ_POSITION_EN
    logic signed [2*SIZE-1:0] pos_reg;

    // Position tracks each HIGH entry in the current direction; clear wins
    always_ff @(posedge clk) begin
        if (rst || pos_clear) begin
            pos_reg <= '0;
        end else if (state_next == S_HIGH && state_reg != S_HIGH) begin
            if (dir_reg) pos_reg <= pos_reg + (2*SIZE)'(1);
            else         pos_reg <= pos_reg - (2*SIZE)'(1);
        end
    end

    assign position = pos_reg;
`endif

endmodule

// File: tb/tb_step_move_sequencer.sv
// Directed bench for step_move_sequencer: single-axis moves, clamp and DIR
// setup, FIFO full / back-to-back execution, drv_en_SM pause, abort, zero
// count and reset mid-move. Offsets are clocks after the push edge.
module tb_step_move_sequencer;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_dir;
    logic [SIZE-1:0] cmd_count;
    logic [SIZE-1:0] cmd_period;
    logic            drv_en_SM;
    logic            abort;
    logic            step;
    logic            dir;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [SIZE-1:0] fifo_level;
`ifdef STEP_SEQ_POSITION_EN
    logic                     pos_clear;
    logic signed [2*SIZE-1:0] position;
`endif

    int total = 0;
    int bad   = 0;
    int offs;
    int high_cycles;
    int rises[$];
    int dones[$];
    logic prev_step;

    always #5 clk = ~clk;

    step_move_sequencer #(
        .SIZE(SIZE), .FIFO_DEPTH(4), .DIR_SETUP(8), .MIN_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_period(cmd_period),
        .drv_en_SM(drv_en_SM), .abort(abort),
`ifdef STEP_SEQ_POSITION_EN
        .pos_clear(pos_clear), .position(position),
`endif
        .step(step), .dir(dir), .busy(busy), .done(done),
        .aborted(aborted), .fifo_level(fifo_level)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        offs++;
        if (step && !prev_step) rises.push_back(offs);
        if (step) high_cycles++;
        if (done) dones.push_back(offs);
        prev_step = step;
    endtask

    task automatic clear_cap();
        offs = -1;
        rises.delete();
        dones.delete();
        high_cycles = 0;
        prev_step = step;
    endtask

    task automatic push(input logic d, input logic [SIZE-1:0] c, input logic [SIZE-1:0] p);
        cmd_valid  = 1'b1;
        cmd_dir    = d;
        cmd_count  = c;
        cmd_period = p;
        cyc();
        cmd_valid  = 1'b0;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_count = '0;
        cmd_period = '0; drv_en_SM = 1'b1; abort = 1'b0;
`ifdef STEP_SEQ_POSITION_EN
        pos_clear = 1'b0;
`endif
        clear_cap();
        cyc(); cyc();
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ready", cmd_ready, 1);
        rst = 1'b0;
        cyc();

        // Basic move: P=8 -> H=2, LOW=6, rises at 3/11/19, done at 26
        clear_cap();
        push(1'b0, 16'd3, 16'd8);
        chk("t1_level", fifo_level, 1);
        chk("t1_busy", busy, 1);
        repeat (29) cyc();
        chk("t1_nrise", rises.size(), 3);
        chk("t1_rise0", q_at(rises, 0), 3);
        chk("t1_rise1", q_at(rises, 1), 11);
        chk("t1_rise2", q_at(rises, 2), 19);
        chk("t1_high", high_cycles, 6);
        chk("t1_ndone", dones.size(), 1);
        chk("t1_done", q_at(dones, 0), 26);
        chk("t1_busy_end", busy, 0);

        // Period clamp to 4 (H=1) and DIR setup: dir at 2, rise at 11, done 14
        clear_cap();
        push(1'b1, 16'd1, 16'd2);
        cyc();
        chk("t2_dir_load", dir, 0);
        cyc();
        chk("t2_dir_set", dir, 1);
        repeat (18) cyc();
        chk("t2_nrise", rises.size(), 1);
        chk("t2_rise0", q_at(rises, 0), 11);
        chk("t2_high", high_cycles, 1);
        chk("t2_done", q_at(dones, 0), 14);

        // Five back-to-back commands: FIFO fills to 4, sixth offer blocked
        clear_cap();
        for (int i = 0; i < 5; i++) push(1'b1, 16'd2, 16'd20);
        chk("t3_level_full", fifo_level, 4);
        chk("t3_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        chk("t3_level_block", fifo_level, 4);
        repeat (300) cyc();
        chk("t3_nrise", rises.size(), 10);
        chk("t3_ndone", dones.size(), 5);
        chk("t3_high", high_cycles, 50);
        chk("t3_busy_end", busy, 0);
        chk("t3_level_end", fifo_level, 0);

        // Pause during HIGH of pulse 1: HIGH completes, LOW holds until re-enable
        clear_cap();
        push(1'b1, 16'd3, 16'd8);
        repeat (3) cyc();
        chk("t4_step_hi", step, 1);
        drv_en_SM = 1'b0;
        repeat (50) cyc();
        chk("t4_step_paused", step, 0);
        drv_en_SM = 1'b1;
        repeat (25) cyc();
        chk("t4_nrise", rises.size(), 3);
        chk("t4_rise0", q_at(rises, 0), 3);
        chk("t4_rise1", q_at(rises, 1), 55);
        chk("t4_rise2", q_at(rises, 2), 63);
        chk("t4_high", high_cycles, 6);
        chk("t4_done", q_at(dones, 0), 70);

        // Abort during 2nd pulse with two commands queued
        clear_cap();
        push(1'b1, 16'd3, 16'd8);
        push(1'b1, 16'd3, 16'd8);
        push(1'b1, 16'd3, 16'd8);
        chk("t5_level", fifo_level, 2);
        repeat (9) cyc();
        chk("t5_step_p2", step, 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_step", step, 0);
        chk("t5_aborted", aborted, 1);
        chk("t5_level0", fifo_level, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_dir_hold", dir, 1);
        cyc();
        chk("t5_aborted_1cyc", aborted, 0);
        repeat (30) cyc();
        chk("t5_nrise", rises.size(), 2);
        chk("t5_ndone", dones.size(), 0);

        // Abort in idle with a same-cycle push: push discarded, aborted pulses
        clear_cap();
        cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_count = 16'd5; cmd_period = 16'd8;
        abort = 1'b1;
        cyc();
        cmd_valid = 1'b0; abort = 1'b0;
        chk("t6_aborted", aborted, 1);
        chk("t6_level", fifo_level, 0);
        chk("t6_busy", busy, 0);
        repeat (10) cyc();
        chk("t6_nrise", rises.size(), 0);

        // Zero count: no step, done at offset 2, dir untouched
        clear_cap();
        push(1'b0, 16'd0, 16'd8);
        repeat (10) cyc();
        chk("t7_nrise", rises.size(), 0);
        chk("t7_ndone", dones.size(), 1);
        chk("t7_done", q_at(dones, 0), 2);
        chk("t7_dir", dir, 1);

        // Reset mid-move with one command still queued
        clear_cap();
        push(1'b1, 16'd5, 16'd8);
        push(1'b1, 16'd5, 16'd8);
        repeat (2) cyc();
        chk("t8_step_hi", step, 1);
        chk("t8_level", fifo_level, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t8_step", step, 0);
        chk("t8_dir", dir, 0);
        chk("t8_level0", fifo_level, 0);
        chk("t8_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
